// File: rtl/result_buffer.sv
// Result FIFO behind the approximate-multiplier datapath: collects products, drains them after batch_done.
// Optional sticky dropped-write flag enabled by defining RESULT_BUF_OVF_FLAG_EN.
module result_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_valid,
  input  logic              batch_done,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              batch_ready,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;
  logic w_out_valid;
  logic w_batch_ready;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_wr_en = (r_state == COLLECT) && res_valid && !w_full;
  assign w_rd_en = w_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_out_valid   = 1'b0;
    w_batch_ready = 1'b0;
    case (r_state)
      COLLECT: if (batch_done) w_next = DRAIN;
      DRAIN: begin
        w_out_valid = !w_empty;
        if (w_empty) w_next = FLUSHED;
      end
      FLUSHED: begin
        w_batch_ready = 1'b1;
        w_next        = COLLECT;
      end
      default: w_next = COLLECT;
    endcase
  end

  // Reads and writes live in different states, so count moves by at most one per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count  <= r_count + CNT_W'(1);
      end else if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count  <= r_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= res_in;
  end

  assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid   = w_out_valid;
  assign batch_ready = w_batch_ready;
  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = r_count;

`ifdef RESULT_BUF_OVF_FLAG_EN
  logic w_drop;
  logic r_overflow;

  // Any res_valid that does not land in storage is a drop: full FIFO or wrong state.
  assign w_drop = res_valid && !w_wr_en;

  always_ff @(posedge clk) begin
    if (!rst)        r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/result_buffer.md
# result_buffer

Output-side buffer sitting directly downstream of the approximate-multiplier controller/datapath. It captures each product presented when the datapath finishes one operand pair, holds up to `DEPTH` results in a circular FIFO, and after the datapath's batch-complete pulse streams them out in arrival order over a valid/ready handshake. A one-cycle `batch_ready` pulse marks the end of the drain, and the block then re-arms for the next batch.

## Interface
- `DATA_W`, default 16: result width. The product of two 8-bit truncated operands, after zero re-insertion.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥ 2.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk` in 1: single clock; all logic updates on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `res_in` in `DATA_W`: product from the datapath result register.
- `res_valid` in 1: one-cycle pulse; `res_in` is valid this cycle. Asserted in the controller's per-pair completion state.
- `batch_done` in 1: one-cycle pulse; the datapath has finished the whole batch.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `out_data` out `DATA_W`: FIFO head entry.
- `out_valid` out 1: `out_data` is valid.
- `batch_ready` out 1: one-cycle pulse when the drain completes.
- `full` out 1: occupancy = `DEPTH`.
- `empty` out 1: occupancy = 0.
- `count` out `CNT_W`: current occupancy.
- `overflow` out 1: sticky dropped-write flag. Only present in behaviour with the macro (see Configuration).

## Operation
- The FIFO uses a write pointer, a read pointer (each `log2(DEPTH)` bits, wrapping modulo `DEPTH`) and `count`.
- FSM states:
  - `COLLECT`: accept writes; `out_valid` = 0. On `batch_done`, go to `DRAIN`.
  - `DRAIN`: writes ignored; `out_valid` = `!empty`; `out_data` = head. When `empty` is true at the start of a cycle, go to `FLUSHED`.
  - `FLUSHED`: `batch_ready` = 1 for exactly one cycle, then return to `COLLECT`.
- Write (`COLLECT` only), when `res_valid` = 1:
  - If `count < DEPTH`, store at the write pointer, advance the pointer, and increment `count`.
  - If `count == DEPTH`, drop the write; the stored data is unchanged.
- `res_valid` and `batch_done` in the same cycle:
  - The write is accepted (if not full) before the transition to `DRAIN`.
- Read (`DRAIN` only), when `out_valid && out_ready`:
  - Advance the read pointer and decrement `count`.
  - `out_data` is combinational from the head entry.
  - `out_data` holds steady while `out_valid && !out_ready`.
- Reads and writes never occur in the same cycle, because they are state-exclusive.
- `res_valid` during `DRAIN` or `FLUSHED` is dropped (counts as a dropped write).
- `batch_done` outside `COLLECT` is ignored.
- `batch_done` while the FIFO is empty: `DRAIN` is entered, then `FLUSHED` follows on the next cycle.
- `out_data` is 0 when `empty`.

## Timing
- Reset (`rst` = 0 at a clock edge) puts the block in the following state:
  - State: `COLLECT`.
  - Pointers and `count`: 0.
  - Outputs: `out_valid` = 0, `batch_ready` = 0, `full` = 0, `empty` = 1, `overflow` = 0, `out_data` = 0.
  - Storage contents are don't-care.
- Reset mid-drain discards all buffered results.
- Write latency: `res_in` sampled at edge N is visible in `count` after edge N.
  - It reaches `out_data` no earlier than the first `DRAIN` cycle.
- `DRAIN` entry: the cycle after the `batch_done` edge, with `out_valid` = 1 if `count` > 0.
- Throughput: one result per cycle while `out_ready` is held high.
- `batch_ready` asserts in the cycle after the cycle in which `DRAIN` observes `empty`.
- `full`, `empty` and `count` are registered-derived and update in the cycle after the causing edge.

## Configuration
- Macro `RESULT_BUF_OVF_FLAG_EN`.
- Defined:
  - `overflow` sets on any dropped write (write when full, or `res_valid` outside `COLLECT`).
  - It stays set until reset; it is not cleared by `batch_ready`.
- Undefined:
  - `overflow` is tied to 0 and has no flag register.
  - Dropping behaviour is identical in both cases.

## Test plan
- Single pass: reset, then write 0x0012, 0x0340, 0x5600, 0x7800 in `COLLECT`, then `batch_done`, with `out_ready` = 1.
  - Required: `out_data` sequence 0x0012, 0x0340, 0x5600, 0x7800 on 4 consecutive cycles.
  - Required: `batch_ready` pulses once after the drain; state returns to `COLLECT` with `count` = 0.
- Full/drop: write 5 values 1..5 with `DEPTH` = 4.
  - Required: `full` = 1 after the 4th write; the drain yields 1, 2, 3, 4 only.
  - Required: `overflow` = 1 with the macro, 0 without.
- Backpressure: `DRAIN` with 3 entries (0xA, 0xB, 0xC); `out_ready` toggles 0, 1, 0, 0, 1, 1.
  - Required: 0xA held until the first accept; output sequence 0xA, 0xB, 0xC with no loss or duplication.
- Simultaneous: `res_valid` with 0x00FF in the same cycle as `batch_done`, with 2 entries already stored.
  - Required: 3 entries drained; 0x00FF is last.
- Wrap-around: two back-to-back batches of 3 results each.
  - Required: second batch output correct after the pointers wrap past index 3.
- Reset mid-drain: assert `rst` = 0 after 1 of 4 entries has been read.
  - Required: next cycle `count` = 0, `out_valid` = 0, `empty` = 1, and no `batch_ready` pulse.
